spi_mem_arbiter: RTL and testbench

Two-port arbiter in front of the shared SPI flash/PSRAM controller. It shares the controller between the CPU sequencer (port A) and a second bus master such as a debug loader or DMA (port B). It latches the winning request, drives the controller's address/type/valid interface until the transfer completes, and returns read data plus a one-cycle acknowledge to the winner.

---
 rtl/spi_mem_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_spi_mem_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter: shares one SPI flash/PSRAM controller between port A (CPU) and port B (DMA/debug).
// Optional build macro SPI_ARB_ROUND_ROBIN_EN swaps fixed port-A priority for round-robin on ties.
module spi_mem_arbiter #(
    parameter int unsigned ISSUE_TIMEOUT = 64
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        a_req_in,
    input  logic [1:0]  a_type_in,
    input  logic [15:0] a_addr_in,
    input  logic [7:0]  a_wdata_in,
    output logic        a_ack_out,
    output logic        a_err_out,
    output logic [15:0] a_rdata_out,
    input  logic        b_req_in,
    input  logic [1:0]  b_type_in,
    input  logic [15:0] b_addr_in,
    input  logic [7:0]  b_wdata_in,
    output logic        b_ack_out,
    output logic        b_err_out,
    output logic [15:0] b_rdata_out,
    output logic [15:0] mem_addr_out,
    output logic        mem_addr_valid_out,
    output logic [1:0]  mem_type_out,
    output logic [7:0]  mem_wdata_out,
    input  logic [15:0] mem_flash_data_in,
    input  logic        mem_flash_valid_in,
    input  logic [7:0]  mem_psram_data_in,
    input  logic        mem_psram_valid_in,
    input  logic        mem_busy_in,
    output logic        grant_b_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] TYPE_NONE    = 2'd0;
    localparam logic [1:0] TYPE_IMEM_RD = 2'd1;
    localparam logic [1:0] TYPE_DMEM_RD = 2'd2;
    localparam logic [1:0] TYPE_DMEM_WR = 2'd3;
    localparam logic       OWNER_A      = 1'b0;
    localparam logic       OWNER_B      = 1'b1;
    localparam logic [7:0] TIMEOUT_C    = 8'(ISSUE_TIMEOUT);

    state_t      state_r;
    state_t      state_s;
    logic        owner_r;
    logic        owner_s;
    logic [15:0] addr_r;
    logic [15:0] addr_s;
    logic [1:0]  type_r;
    logic [1:0]  type_s;
    logic [7:0]  wdata_r;
    logic [7:0]  wdata_s;
    logic [7:0]  cnt_r;
    logic [7:0]  cnt_s;
    logic        err_s;
    logic        cap_s;
    logic [15:0] cap_data_s;
    logic        a_valid_s;
    logic        b_valid_s;
    logic        pick_b_s;
    logic        busy_phase_s;
    logic        a_done_s;
    logic        b_done_s;

    logic        mem_valid_r;
    logic [1:0]  mem_type_r;
    logic [15:0] mem_addr_r;
    logic [7:0]  mem_wdata_r;
    logic        a_ack_r;
    logic        a_err_r;
    logic [15:0] a_rdata_r;
    logic        b_ack_r;
    logic        b_err_r;
    logic [15:0] b_rdata_r;
    logic        grant_b_r;

    assign a_valid_s = a_req_in && (a_type_in != TYPE_NONE);
    assign b_valid_s = b_req_in && (b_type_in != TYPE_NONE);

`ifdef SPI_ARB_ROUND_ROBIN_EN
    logic last_owner_r;
    logic last_owner_s;

    // While in DONE the flag has not caught up yet, so the current owner is the last one.
    assign last_owner_s = (state_r == ST_DONE) ? owner_r : last_owner_r;
    assign pick_b_s     = b_valid_s && (!a_valid_s || (last_owner_s == OWNER_A));

    // Last-owner flag, reset to B so that A takes the first tie.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            last_owner_r <= OWNER_B;
        end else if (state_r == ST_DONE) begin
            last_owner_r <= owner_r;
        end else begin
            last_owner_r <= last_owner_r;
        end
    end
`else
    assign pick_b_s = b_valid_s && !a_valid_s;
`endif

    // Next-state, request latching and completion detection.
    always_comb begin
        state_s    = state_r;
        owner_s    = owner_r;
        addr_s     = addr_r;
        type_s     = type_r;
        wdata_s    = wdata_r;
        cnt_s      = cnt_r;
        err_s      = 1'b0;
        cap_s      = 1'b0;
        cap_data_s = 16'h0000;
        case (state_r)
            // DONE arbitrates like IDLE so back-to-back transfers lose only one valid cycle.
            ST_IDLE, ST_DONE: begin
                if (a_valid_s || b_valid_s) begin
                    state_s = ST_ISSUE;
                    owner_s = pick_b_s;
                    addr_s  = pick_b_s ? b_addr_in : a_addr_in;
                    type_s  = pick_b_s ? b_type_in : a_type_in;
                    wdata_s = pick_b_s ? b_wdata_in : a_wdata_in;
                    cnt_s   = 8'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (mem_busy_in) begin
                    state_s = ST_WAIT;
                end else if (cnt_r == TIMEOUT_C) begin
                    state_s = ST_DONE;
                    err_s   = 1'b1;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            ST_WAIT: begin
                case (type_r)
                    TYPE_IMEM_RD: begin
                        if (mem_flash_valid_in) begin
                            state_s    = ST_DONE;
                            cap_s      = 1'b1;
                            cap_data_s = mem_flash_data_in;
                        end else begin
                            state_s = ST_WAIT;
                        end
                    end
                    TYPE_DMEM_RD: begin
                        if (mem_psram_valid_in) begin
                            state_s    = ST_DONE;
                            cap_s      = 1'b1;
                            cap_data_s = {8'h00, mem_psram_data_in};
                        end else begin
                            state_s = ST_WAIT;
                        end
                    end
                    TYPE_DMEM_WR: begin
                        if (!mem_busy_in) begin
                            state_s = ST_DONE;
                        end else begin
                            state_s = ST_WAIT;
                        end
                    end
                    default: state_s = ST_IDLE;
                endcase
            end
            default: state_s = ST_IDLE;
        endcase
    end

    assign busy_phase_s = (state_s == ST_ISSUE) || (state_s == ST_WAIT);
    assign a_done_s     = (state_s == ST_DONE) && (owner_s == OWNER_A);
    assign b_done_s     = (state_s == ST_DONE) && (owner_s == OWNER_B);

    // State, latches and registered outputs; outputs are decoded from the next state.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_r     <= ST_IDLE;
            owner_r     <= OWNER_A;
            addr_r      <= 16'h0000;
            type_r      <= TYPE_NONE;
            wdata_r     <= 8'h00;
            cnt_r       <= 8'd0;
            mem_valid_r <= 1'b0;
            mem_type_r  <= TYPE_NONE;
            mem_addr_r  <= 16'h0000;
            mem_wdata_r <= 8'h00;
            a_ack_r     <= 1'b0;
            a_err_r     <= 1'b0;
            a_rdata_r   <= 16'h0000;
            b_ack_r     <= 1'b0;
            b_err_r     <= 1'b0;
            b_rdata_r   <= 16'h0000;
            grant_b_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            owner_r     <= owner_s;
            addr_r      <= addr_s;
            type_r      <= type_s;
            wdata_r     <= wdata_s;
            cnt_r       <= cnt_s;
            mem_valid_r <= busy_phase_s;
            mem_type_r  <= busy_phase_s ? type_s : TYPE_NONE;
            mem_addr_r  <= busy_phase_s ? addr_s : 16'h0000;
            mem_wdata_r <= busy_phase_s ? wdata_s : 8'h00;
            a_ack_r     <= a_done_s;
            a_err_r     <= a_done_s && err_s;
            b_ack_r     <= b_done_s;
            b_err_r     <= b_done_s && err_s;
            a_rdata_r   <= (a_done_s && cap_s) ? cap_data_s : a_rdata_r;
            b_rdata_r   <= (b_done_s && cap_s) ? cap_data_s : b_rdata_r;
            grant_b_r   <= (state_s != ST_IDLE) && (owner_s == OWNER_B);
        end
    end

    assign mem_addr_valid_out = mem_valid_r;
    assign mem_type_out       = mem_type_r;
    assign mem_addr_out       = mem_addr_r;
    assign mem_wdata_out      = mem_wdata_r;
    assign a_ack_out          = a_ack_r;
    assign a_err_out          = a_err_r;
    assign a_rdata_out        = a_rdata_r;
    assign b_ack_out          = b_ack_r;
    assign b_err_out          = b_err_r;
    assign b_rdata_out        = b_rdata_r;
    assign grant_b_out        = grant_b_r;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed bench for spi_mem_arbiter: a table of single transfers against a small controller
// model, plus hand-written tie, timeout, reset and idle-type sequences.
module tb_spi_mem_arbiter;

    logic        clk_in;
    logic        reset_in;
    logic        a_req_in;
    logic [1:0]  a_type_in;
    logic [15:0] a_addr_in;
    logic [7:0]  a_wdata_in;
    logic        a_ack_out;
    logic        a_err_out;
    logic [15:0] a_rdata_out;
    logic        b_req_in;
    logic [1:0]  b_type_in;
    logic [15:0] b_addr_in;
    logic [7:0]  b_wdata_in;
    logic        b_ack_out;
    logic        b_err_out;
    logic [15:0] b_rdata_out;
    logic [15:0] mem_addr_out;
    logic        mem_addr_valid_out;
    logic [1:0]  mem_type_out;
    logic [7:0]  mem_wdata_out;
    logic [15:0] mem_flash_data_in;
    logic        mem_flash_valid_in;
    logic [7:0]  mem_psram_data_in;
    logic        mem_psram_valid_in;
    logic        mem_busy_in;
    logic        grant_b_out;

    int n_cmp = 0;
    int n_bad = 0;

    spi_mem_arbiter #(.ISSUE_TIMEOUT(64)) dut (
        .clk_in(clk_in), .reset_in(reset_in),
        .a_req_in(a_req_in), .a_type_in(a_type_in), .a_addr_in(a_addr_in), .a_wdata_in(a_wdata_in),
        .a_ack_out(a_ack_out), .a_err_out(a_err_out), .a_rdata_out(a_rdata_out),
        .b_req_in(b_req_in), .b_type_in(b_type_in), .b_addr_in(b_addr_in), .b_wdata_in(b_wdata_in),
        .b_ack_out(b_ack_out), .b_err_out(b_err_out), .b_rdata_out(b_rdata_out),
        .mem_addr_out(mem_addr_out), .mem_addr_valid_out(mem_addr_valid_out),
        .mem_type_out(mem_type_out), .mem_wdata_out(mem_wdata_out),
        .mem_flash_data_in(mem_flash_data_in), .mem_flash_valid_in(mem_flash_valid_in),
        .mem_psram_data_in(mem_psram_data_in), .mem_psram_valid_in(mem_psram_valid_in),
        .mem_busy_in(mem_busy_in), .grant_b_out(grant_b_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // One transfer: busy high for cycles [bs,be), correct data pulse at pk, wrong-kind pulse at jk.
    // Cycle 0 is the first ISSUE cycle; exp_ack is the DONE cycle.
    typedef struct {
        logic        port;
        logic [1:0]  typ;
        logic [15:0] addr;
        logic [7:0]  wdata;
        int          bs;
        int          be;
        int          pk;
        int          jk;
        logic [15:0] pdata;
        int          exp_ack;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic clear_mem();
        mem_busy_in        = 1'b0;
        mem_flash_valid_in = 1'b0;
        mem_flash_data_in  = 16'h0000;
        mem_psram_valid_in = 1'b0;
        mem_psram_data_in  = 8'h00;
    endtask

    task automatic clear_req();
        a_req_in = 1'b0; a_type_in = 2'd0; a_addr_in = 16'h0000; a_wdata_in = 8'h00;
        b_req_in = 1'b0; b_type_in = 2'd0; b_addr_in = 16'h0000; b_wdata_in = 8'h00;
    endtask

    task automatic run_vec(input vec_t v);
        logic right;
        logic junk;
        if (v.port) begin
            b_req_in = 1'b1; b_type_in = v.typ; b_addr_in = v.addr; b_wdata_in = v.wdata;
        end else begin
            a_req_in = 1'b1; a_type_in = v.typ; a_addr_in = v.addr; a_wdata_in = v.wdata;
        end
        step();
        for (int k = 0; k <= v.exp_ack; k++) begin
            if (k < v.exp_ack) begin
                check("phase", 32'({mem_addr_valid_out, a_ack_out, b_ack_out, mem_type_out,
                                    mem_addr_out, mem_wdata_out, grant_b_out}),
                               32'({1'b1, 2'b00, v.typ, v.addr, v.wdata, v.port}));
                right       = (k == v.pk);
                junk        = (k == v.jk);
                mem_busy_in = (k >= v.bs) && (k < v.be);
                if (v.typ == 2'd1) begin
                    mem_flash_valid_in = right;
                    mem_flash_data_in  = right ? v.pdata : 16'h0000;
                    mem_psram_valid_in = junk;
                    mem_psram_data_in  = junk ? 8'hFF : 8'h00;
                end else begin
                    mem_psram_valid_in = right;
                    mem_psram_data_in  = right ? v.pdata[7:0] : 8'h00;
                    mem_flash_valid_in = junk;
                    mem_flash_data_in  = junk ? 16'hFFFF : 16'h0000;
                end
                step();
            end else begin
                clear_mem();
                check("ack", 32'({a_ack_out, b_ack_out}), v.port ? 32'h1 : 32'h2);
                check("err", 32'({a_err_out, b_err_out}), 32'h0);
                check("rdata", 32'(v.port ? b_rdata_out : a_rdata_out), 32'(v.exp_rdata));
                check("done_bus", 32'({mem_addr_valid_out, mem_type_out}), 32'h0);
            end
        end
        clear_req();
        step();
        check("idle", 32'({mem_addr_valid_out, a_ack_out, b_ack_out, grant_b_out}), 32'h0);
    endtask

    initial begin
        logic to_bad;
        vecs[0] = '{1'b0, 2'd1, 16'h0010, 8'h00, 2, 23, 22, -1, 16'hA55A, 23, 16'hA55A};
        vecs[1] = '{1'b1, 2'd3, 16'h1234, 8'h5C, 1, 11, -1, -1, 16'h0000, 12, 16'h0000};
        vecs[2] = '{1'b1, 2'd2, 16'h0200, 8'h00, 0, 6, 4, 2, 16'h007E, 5, 16'h007E};
        vecs[3] = '{1'b0, 2'd3, 16'h00FF, 8'hA3, 3, 4, -1, -1, 16'h0000, 5, 16'hA55A};
        vecs[4] = '{1'b1, 2'd1, 16'hBEEF, 8'h00, 1, 4, 2, 1, 16'h1357, 3, 16'h1357};

        clear_req();
        clear_mem();
        reset_in = 1'b1;
        step();
        step();
        check("reset_out", 32'({mem_addr_valid_out, mem_type_out, mem_addr_out, mem_wdata_out,
                                grant_b_out, a_ack_out, a_err_out, b_ack_out, b_err_out}), 32'h0);
        check("reset_rdata", 32'({a_rdata_out, b_rdata_out}), 32'h0);
        reset_in = 1'b0;
        step();

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
        end

        // Simultaneous requests: A first, inputs changed/dropped mid-transfer, then B.
        a_req_in = 1'b1; a_type_in = 2'd2; a_addr_in = 16'h0100;
        b_req_in = 1'b1; b_type_in = 2'd2; b_addr_in = 16'h0200;
        step();
        check("tie_grant_a", 32'({mem_addr_valid_out, grant_b_out, mem_addr_out}), 32'({2'b10, 16'h0100}));
        a_addr_in = 16'h0F0F; a_type_in = 2'd3; mem_busy_in = 1'b1;
        step();
        check("latched", 32'({mem_type_out, mem_addr_out}), 32'({2'd2, 16'h0100}));
        a_req_in = 1'b0; mem_psram_valid_in = 1'b1; mem_psram_data_in = 8'h11;
        step();
        clear_mem();
        check("tie_a_ack", 32'({a_ack_out, b_ack_out, mem_addr_valid_out, a_rdata_out}), 32'({3'b100, 16'h0011}));
        step();
        check("b_after_a", 32'({mem_addr_valid_out, grant_b_out, mem_addr_out}), 32'({2'b11, 16'h0200}));
        mem_busy_in = 1'b1;
        step();
        mem_psram_valid_in = 1'b1; mem_psram_data_in = 8'h22;
        step();
        clear_mem();
        check("tie_b_ack", 32'({a_ack_out, b_ack_out, mem_addr_valid_out, b_rdata_out}), 32'({3'b010, 16'h0022}));
        clear_req();
        step();
        check("tie_idle", 32'({mem_addr_valid_out, a_ack_out, b_ack_out}), 32'h0);

        // Busy never rises: abort with err exactly 65 cycles after ISSUE entry.
        a_req_in = 1'b1; a_type_in = 2'd1; a_addr_in = 16'h0040;
        step();
        to_bad = 1'b0;
        for (int k = 0; k < 65; k++) begin
            if (a_ack_out || b_ack_out || !mem_addr_valid_out) to_bad = 1'b1;
            step();
        end
        check("timeout_phase", 32'(to_bad), 32'h0);
        check("timeout_ack", 32'({a_ack_out, a_err_out, b_ack_out, mem_addr_valid_out}), 32'hC);
        clear_req();
        step();
        check("timeout_idle", 32'({a_ack_out, a_err_out, mem_addr_valid_out}), 32'h0);

        // Reset in WAIT: everything clears, no ack, the held request is granted again.
        b_req_in = 1'b1; b_type_in = 2'd2; b_addr_in = 16'h0300;
        step();
        mem_busy_in = 1'b1;
        step();
        step();
        check("pre_reset_wait", 32'({mem_addr_valid_out, grant_b_out}), 32'h3);
        reset_in = 1'b1; mem_busy_in = 1'b0;
        step();
        check("midreset_out", 32'({mem_addr_valid_out, mem_type_out, mem_addr_out, mem_wdata_out,
                                   grant_b_out, a_ack_out, a_err_out, b_ack_out, b_err_out}), 32'h0);
        check("midreset_rdata", 32'({a_rdata_out, b_rdata_out}), 32'h0);
        reset_in = 1'b0;
        step();
        check("regrant", 32'({mem_addr_valid_out, grant_b_out, mem_addr_out}), 32'({2'b11, 16'h0300}));
        mem_busy_in = 1'b1;
        step();
        mem_psram_valid_in = 1'b1; mem_psram_data_in = 8'h44;
        step();
        clear_mem();
        check("regrant_ack", 32'({b_ack_out, a_ack_out, b_rdata_out}), 32'({2'b10, 16'h0044}));
        clear_req();
        step();

        // Request with type 0 is ignored.
        a_req_in = 1'b1; a_type_in = 2'd0; a_addr_in = 16'h5555;
        for (int k = 0; k < 3; k++) begin
            step();
            check("type0_idle", 32'({mem_addr_valid_out, grant_b_out, a_ack_out}), 32'h0);
        end
        clear_req();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
